// File: rtl/rat_ckpt_if.sv
// Rename-stage bundle between decode/dispatch and the register alias table.
// The slave modport is the RAT side.
interface rat_ckpt_if #(
  parameter int PREG_W   = 6,
  parameter int WIDTH    = 2,
  parameter int RET_W    = 2,
  parameter int CKPT_NUM = 4
);
  localparam int CW = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1;

  logic [WIDTH-1:0]             ren_valid;
  logic [WIDTH-1:0][4:0]        ren_dst;
  logic [WIDTH-1:0][4:0]        ren_src1;
  logic [WIDTH-1:0][4:0]        ren_src2;
  logic [WIDTH-1:0][PREG_W-1:0] ren_preg;
  logic [WIDTH-1:0]             src1_valid;
  logic [WIDTH-1:0]             src2_valid;
  logic [WIDTH-1:0][PREG_W-1:0] src1_id;
  logic [WIDTH-1:0][PREG_W-1:0] src2_id;
  logic [WIDTH-1:0][PREG_W-1:0] old_preg;
  logic [RET_W-1:0]             ret_valid;
  logic [RET_W-1:0][4:0]        ret_dst;
  logic [RET_W-1:0][PREG_W-1:0] ret_preg;
  logic                         ckpt_req;
  logic [CW-1:0]                ckpt_id;
  logic                         ckpt_full;
  logic                         ckpt_release;
  logic                         recover_valid;
  logic [CW-1:0]                recover_id;
  logic                         flush;

  modport master (
    output ren_valid, ren_dst, ren_src1, ren_src2, ren_preg,
    output ret_valid, ret_dst, ret_preg,
    output ckpt_req, ckpt_release, recover_valid, recover_id, flush,
    input  src1_valid, src2_valid, src1_id, src2_id, old_preg, ckpt_id, ckpt_full
  );

  modport slave (
    input  ren_valid, ren_dst, ren_src1, ren_src2, ren_preg,
    input  ret_valid, ret_dst, ret_preg,
    input  ckpt_req, ckpt_release, recover_valid, recover_id, flush,
    output src1_valid, src2_valid, src1_id, src2_id, old_preg, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/rat_ckpt.sv
// Register alias table with branch checkpoints: combinational source lookup with
// intra-group bypass, retire clears, snapshot/recover and flush.
module rat_ckpt #(
  parameter int CREG_NUM = 32,
  parameter int PREG_W   = 6,
  parameter int WIDTH    = 2,
  parameter int RET_W    = 2,
  parameter int CKPT_NUM = 4
) (
  input logic       clk_i,
  input logic       rst_i,
  rat_ckpt_if.slave rat_if
);
  localparam int CW = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1;
  localparam logic [CW-1:0] PTR_ONE  = 1;
  localparam logic [CW:0]   CNT_ONE  = 1;
  localparam logic [CW:0]   CNT_FULL = (CW+1)'(CKPT_NUM);

  typedef logic [CREG_NUM-1:0]             vmap_t;
  typedef logic [CREG_NUM-1:0][PREG_W-1:0] tmap_t;

  vmap_t                v_q, v_d;
  tmap_t                t_q, t_d;
  vmap_t [CKPT_NUM-1:0] cv_q, cv_d;
  tmap_t [CKPT_NUM-1:0] ct_q, ct_d;
  logic [CW-1:0]        head_q, head_d;
  logic [CW-1:0]        tail_q, tail_d;
  logic [CW:0]          cnt_q, cnt_d;
  logic                 full;

  // Earlier slots in the same group override the table; the highest matching slot wins.
  function automatic logic lk_v(input logic [4:0] r, input int slot, input vmap_t v,
                                input logic [WIDTH-1:0] rv, input logic [WIDTH-1:0][4:0] rd);
    logic res;
    res = 1'b0;
    if (r != 5'd0) begin
      res = v[r];
      for (int j = 0; j < WIDTH; j++)
        if (j < slot && rv[j] && rd[j] == r) res = 1'b1;
    end
    return res;
  endfunction

  function automatic logic [PREG_W-1:0] lk_id(input logic [4:0] r, input int slot, input tmap_t t,
                                              input logic [WIDTH-1:0] rv,
                                              input logic [WIDTH-1:0][4:0] rd,
                                              input logic [WIDTH-1:0][PREG_W-1:0] rp);
    logic [PREG_W-1:0] res;
    res = '0;
    if (r != 5'd0) begin
      res = t[r];
      for (int j = 0; j < WIDTH; j++)
        if (j < slot && rv[j] && rd[j] == r) res = rp[j];
    end
    return res;
  endfunction

  assign full             = (cnt_q == CNT_FULL);
  assign rat_if.ckpt_full = full;
  assign rat_if.ckpt_id   = tail_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      rat_if.src1_valid[i] = lk_v(rat_if.ren_src1[i], i, v_q, rat_if.ren_valid, rat_if.ren_dst);
      rat_if.src2_valid[i] = lk_v(rat_if.ren_src2[i], i, v_q, rat_if.ren_valid, rat_if.ren_dst);
      rat_if.src1_id[i]    = lk_id(rat_if.ren_src1[i], i, t_q, rat_if.ren_valid, rat_if.ren_dst,
                                   rat_if.ren_preg);
      rat_if.src2_id[i]    = lk_id(rat_if.ren_src2[i], i, t_q, rat_if.ren_valid, rat_if.ren_dst,
                                   rat_if.ren_preg);
      rat_if.old_preg[i]   = lk_id(rat_if.ren_dst[i], i, t_q, rat_if.ren_valid, rat_if.ren_dst,
                                   rat_if.ren_preg);
    end
  end

  always_comb begin
    v_d    = v_q;
    t_d    = t_q;
    cv_d   = cv_q;
    ct_d   = ct_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    // Retire clears compare against the pre-cycle mapping, live and per snapshot.
    for (int k = 0; k < RET_W; k++) begin
      if (rat_if.ret_valid[k]) begin
        if (t_q[rat_if.ret_dst[k]] == rat_if.ret_preg[k]) v_d[rat_if.ret_dst[k]] = 1'b0;
        for (int s = 0; s < CKPT_NUM; s++)
          if (ct_q[s][rat_if.ret_dst[k]] == rat_if.ret_preg[k]) cv_d[s][rat_if.ret_dst[k]] = 1'b0;
      end
    end

    if (rat_if.flush) begin
      v_d    = '0;
      head_d = tail_q;
      cnt_d  = '0;
    end else if (rat_if.recover_valid) begin
      v_d    = cv_d[rat_if.recover_id];
      t_d    = ct_q[rat_if.recover_id];
      tail_d = rat_if.recover_id;
      cnt_d  = {1'b0, rat_if.recover_id - head_q};
      if (rat_if.ckpt_release && cnt_d != '0) begin
        head_d = head_q + PTR_ONE;
        cnt_d  = cnt_d - CNT_ONE;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rat_if.ren_valid[i] && rat_if.ren_dst[i] != 5'd0) begin
          t_d[rat_if.ren_dst[i]] = rat_if.ren_preg[i];
          v_d[rat_if.ren_dst[i]] = 1'b1;
        end
      end
      if (rat_if.ckpt_req && !full) begin
        cv_d[tail_q] = v_d;
        ct_d[tail_q] = t_d;
        tail_d       = tail_q + PTR_ONE;
        cnt_d        = cnt_d + CNT_ONE;
      end
      if (rat_if.ckpt_release && cnt_q != '0) begin
        head_d = head_q + PTR_ONE;
        cnt_d  = cnt_d - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q    <= '0;
      t_q    <= '0;
      cv_q   <= '0;
      ct_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      t_q    <= t_d;
      cv_q   <= cv_d;
      ct_q   <= ct_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  a_recover_live: assert property (@(posedge clk_i) disable iff (rst_i)
    (rat_if.recover_valid && !rat_if.flush) |-> ({1'b0, rat_if.recover_id - head_q} < cnt_q));

endmodule

// File: tb/tb_rat_ckpt.sv
// Self-checking bench for rat_ckpt: directed literal cases, then randomized traffic
// compared every cycle against an array-based model of the alias table.
module tb_rat_ckpt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rat_ckpt_if rif ();
  rat_ckpt dut (.clk_i(clk), .rst_i(rst), .rat_if(rif));

  int n_vec = 0;
  int n_err = 0;

  bit [31:0] m_v;
  int        m_t [32];
  bit [31:0] s_v [4];
  int        s_t [4][32];
  int        m_head, m_tail, m_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = '0;
    for (int r = 0; r < 32; r++) m_t[r] = 0;
    for (int s = 0; s < 4; s++) begin
      s_v[s] = '0;
      for (int r = 0; r < 32; r++) s_t[s][r] = 0;
    end
    m_head = 0; m_tail = 0; m_count = 0;
  endtask

  function automatic bit exp_v(input int slot, input int r);
    bit v;
    v = 0;
    if (r != 0) begin
      v = m_v[r];
      for (int j = 0; j < slot; j++)
        if (rif.ren_valid[j] && int'(rif.ren_dst[j]) == r) v = 1;
    end
    return v;
  endfunction

  function automatic int exp_id(input int slot, input int r);
    int id;
    id = 0;
    if (r != 0) begin
      id = m_t[r];
      for (int j = 0; j < slot; j++)
        if (rif.ren_valid[j] && int'(rif.ren_dst[j]) == r) id = int'(rif.ren_preg[j]);
    end
    return id;
  endfunction

  task automatic compare_model();
    for (int i = 0; i < 2; i++) begin
      chk("src1_valid", rif.src1_valid[i], exp_v(i, int'(rif.ren_src1[i])));
      chk("src1_id",    rif.src1_id[i],    exp_id(i, int'(rif.ren_src1[i])));
      chk("src2_valid", rif.src2_valid[i], exp_v(i, int'(rif.ren_src2[i])));
      chk("src2_id",    rif.src2_id[i],    exp_id(i, int'(rif.ren_src2[i])));
      chk("old_preg",   rif.old_preg[i],   exp_id(i, int'(rif.ren_dst[i])));
    end
    chk("ckpt_id",   rif.ckpt_id,   m_tail);
    chk("ckpt_full", rif.ckpt_full, (m_count == 4) ? 1 : 0);
  endtask

  task automatic model_step();
    bit [31:0] nv;
    int nt [32];
    int rd, rp, rid;
    bit take, rel_ok;
    nv = m_v;
    for (int r = 0; r < 32; r++) nt[r] = m_t[r];
    for (int k = 0; k < 2; k++) begin
      if (rif.ret_valid[k]) begin
        rd = int'(rif.ret_dst[k]);
        rp = int'(rif.ret_preg[k]);
        if (m_t[rd] == rp) nv[rd] = 0;
        for (int s = 0; s < 4; s++) if (s_t[s][rd] == rp) s_v[s][rd] = 0;
      end
    end
    if (rif.flush) begin
      nv = '0;
      m_head = m_tail;
      m_count = 0;
    end else if (rif.recover_valid) begin
      rid = int'(rif.recover_id);
      nv = s_v[rid];
      for (int r = 0; r < 32; r++) nt[r] = s_t[rid][r];
      m_count = (rid - m_head + 4) % 4;
      m_tail = rid;
      if (rif.ckpt_release && m_count > 0) begin
        m_head = (m_head + 1) % 4;
        m_count--;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rif.ren_valid[i] && rif.ren_dst[i] != 0) begin
          nt[int'(rif.ren_dst[i])] = int'(rif.ren_preg[i]);
          nv[int'(rif.ren_dst[i])] = 1;
        end
      end
      take   = rif.ckpt_req && m_count < 4;
      rel_ok = rif.ckpt_release && m_count > 0;
      if (take) begin
        s_v[m_tail] = nv;
        for (int r = 0; r < 32; r++) s_t[m_tail][r] = nt[r];
        m_tail = (m_tail + 1) % 4;
        m_count++;
      end
      if (rel_ok) begin
        m_head = (m_head + 1) % 4;
        m_count--;
      end
    end
    m_v = nv;
    for (int r = 0; r < 32; r++) m_t[r] = nt[r];
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rif.ren_valid = '0; rif.ren_dst = '0; rif.ren_src1 = '0; rif.ren_src2 = '0; rif.ren_preg = '0;
    rif.ret_valid = '0; rif.ret_dst = '0; rif.ret_preg = '0;
    rif.ckpt_req = 0; rif.ckpt_release = 0; rif.recover_valid = 0; rif.recover_id = '0;
    rif.flush = 0;
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      rif.ren_valid[i] = 1'($urandom_range(0, 1));
      rif.ren_dst[i]   = 5'($urandom_range(0, 7));
      rif.ren_src1[i]  = 5'($urandom_range(0, 7));
      rif.ren_src2[i]  = 5'($urandom_range(0, 7));
      rif.ren_preg[i]  = 6'($urandom_range(1, 63));
    end
    for (int k = 0; k < 2; k++) begin
      int rd, sel;
      rd  = $urandom_range(0, 7);
      sel = $urandom_range(0, 2);
      rif.ret_valid[k] = 1'($urandom_range(0, 1));
      rif.ret_dst[k]   = 5'(rd);
      if (sel == 0)      rif.ret_preg[k] = 6'(m_t[rd]);
      else if (sel == 1) rif.ret_preg[k] = 6'(s_t[$urandom_range(0, 3)][rd]);
      else               rif.ret_preg[k] = 6'($urandom_range(0, 63));
    end
    rif.ckpt_req     = ($urandom_range(0, 2) == 0);
    rif.ckpt_release = ($urandom_range(0, 3) == 0);
    rif.flush        = ($urandom_range(0, 24) == 0);
    if (m_count > 0 && $urandom_range(0, 7) == 0) begin
      rif.recover_valid = 1;
      rif.recover_id    = 2'((m_head + $urandom_range(0, m_count - 1)) % 4);
    end else begin
      rif.recover_valid = 0;
      rif.recover_id    = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    rif.ren_src1[0] = 5; #1;
    chk("rst_src1_valid", rif.src1_valid[0], 0);
    chk("rst_src1_id", rif.src1_id[0], 0);
    chk("rst_ckpt_id", rif.ckpt_id, 0);
    chk("rst_ckpt_full", rif.ckpt_full, 0);
    cycle();

    idle(); rif.ren_valid = 2'b01; rif.ren_dst[0] = 3; rif.ren_preg[0] = 10; rif.ren_src1[1] = 3; #1;
    chk("bypass_valid", rif.src1_valid[1], 1);
    chk("bypass_id", rif.src1_id[1], 10);
    cycle();
    idle(); rif.ren_src1[0] = 3; #1;
    chk("map3_valid", rif.src1_valid[0], 1);
    chk("map3_id", rif.src1_id[0], 10);
    cycle();

    idle(); rif.ren_valid = 2'b11; rif.ren_dst[0] = 7; rif.ren_dst[1] = 7;
    rif.ren_preg[0] = 20; rif.ren_preg[1] = 21; #1;
    chk("dup_old_preg1", rif.old_preg[1], 20);
    cycle();
    idle(); rif.ren_src1[0] = 7; rif.ret_valid = 2'b01; rif.ret_dst[0] = 7; rif.ret_preg[0] = 20; #1;
    chk("dup_t7", rif.src1_id[0], 21);
    cycle();
    idle(); rif.ren_src1[0] = 7; rif.ret_valid = 2'b01; rif.ret_dst[0] = 7; rif.ret_preg[0] = 21; #1;
    chk("stale_ret_v7", rif.src1_valid[0], 1);
    cycle();
    idle(); rif.ren_src1[0] = 7; #1;
    chk("ret_clear_v7", rif.src1_valid[0], 0);
    cycle();

    idle(); rif.ren_valid = 2'b01; rif.ren_dst[0] = 4; rif.ren_preg[0] = 12; cycle();
    idle(); rif.ckpt_req = 1; #1;
    chk("ckpt_first_id", rif.ckpt_id, 0);
    cycle();
    idle(); rif.ren_valid = 2'b01; rif.ren_dst[0] = 4; rif.ren_preg[0] = 13; cycle();
    idle(); rif.recover_valid = 1; rif.recover_id = 0; cycle();
    idle(); rif.ren_src1[0] = 4; #1;
    chk("recover_id4", rif.src1_id[0], 12);
    chk("recover_v4", rif.src1_valid[0], 1);
    chk("recover_ckpt_id", rif.ckpt_id, 0);
    chk("recover_full", rif.ckpt_full, 0);
    cycle();

    idle(); rif.ckpt_req = 1; cycle();
    idle(); rif.ren_valid = 2'b01; rif.ren_dst[0] = 4; rif.ren_preg[0] = 13;
    rif.ret_valid = 2'b01; rif.ret_dst[0] = 4; rif.ret_preg[0] = 12; cycle();
    idle(); rif.recover_valid = 1; rif.recover_id = 0; cycle();
    idle(); rif.ren_src1[0] = 4; #1;
    chk("snap_ret_clear_v4", rif.src1_valid[0], 0);
    cycle();

    idle(); rif.ckpt_req = 1;
    repeat (4) cycle();
    chk("four_ckpt_full", rif.ckpt_full, 1);
    cycle();
    chk("fifth_ignored_full", rif.ckpt_full, 1);
    chk("fifth_ignored_id", rif.ckpt_id, 0);
    idle(); rif.flush = 1; cycle();
    idle(); rif.ren_src1[0] = 3; #1;
    chk("flush_v3", rif.src1_valid[0], 0);
    chk("flush_full", rif.ckpt_full, 0);
    rif.ckpt_release = 1; cycle();
    idle(); #1;
    chk("empty_release_id", rif.ckpt_id, 0);
    chk("empty_release_full", rif.ckpt_full, 0);

    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        rst = 1; #1; rst = 0;
        model_reset();
        idle(); #1;
        chk("midrst_ckpt_id", rif.ckpt_id, 0);
        chk("midrst_full", rif.ckpt_full, 0);
      end
      drive_random();
      cycle();
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
